input_spi_rx: RTL

- Receive-side counterpart of the hash-table output serializer: decodes the 3-slot pulse-coded serial line back into bytes.
- Each bit is one symbol of 3 clock slots:
  - bit 1 = high, high, low
  - bit 0 = high, low, low
- Bits arrive LSB first, 8 per byte, framed by an enable line, with both ends on the same clock.
- Decoded bytes go to downstream logic (hash-table / crypto input) over a valid/ready handshake, with framing-error and overrun reporting.

---
 rtl/input_spi_rx.sv | 126 ++++++++++++
 1 files changed

// File: rtl/input_spi_rx.sv
// Receiver for the 3-slot pulse-coded serial link (1 = HHL, 0 = HLL), LSB first.
// Decoded bytes are offered on a valid/ready output register with error pulses.
module input_spi_rx #(
   parameter int unsigned DATA_W    = 8,
   parameter bit          LSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in,
   input  logic              en_in,
   output logic [DATA_W-1:0] data_out,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              busy,
   output logic              frame_err,
   output logic              overrun
);

   localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_shift;
   logic              w_complete;
   logic [CNT_W-1:0]  w_idx;

   assign w_complete = (r_state == S_STOP) && !in && (r_cnt == LAST_BIT);
   assign w_idx      = LSB_FIRST ? r_cnt : CNT_W'(LAST_BIT - r_cnt);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_shift   <= '0;
         data_out  <= '0;
         rx_valid  <= 1'b0;
         busy      <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;

         // symbol decoder; every error path discards the partial byte
         case (r_state)
            S_IDLE: begin
               if (en_in) begin
                  if (in) begin
                     r_state <= S_DATA;
                     busy    <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
            end
            S_START: begin
               if (en_in && in) begin
                  r_state <= S_DATA;
               end else begin
                  frame_err <= 1'b1;
                  r_state   <= S_IDLE;
                  busy      <= 1'b0;
                  r_cnt     <= '0;
                  r_shift   <= '0;
               end
            end
            S_DATA: begin
               if (en_in) begin
                  r_shift[w_idx] <= in;
                  r_state        <= S_STOP;
               end else begin
                  frame_err <= 1'b1;
                  r_state   <= S_IDLE;
                  busy      <= 1'b0;
                  r_cnt     <= '0;
                  r_shift   <= '0;
               end
            end
            S_STOP: begin
               if (in) begin
                  frame_err <= 1'b1;
                  r_state   <= S_IDLE;
                  busy      <= 1'b0;
                  r_cnt     <= '0;
                  r_shift   <= '0;
               end else if (r_cnt == LAST_BIT) begin
                  r_state <= S_IDLE;
                  busy    <= 1'b0;
                  r_cnt   <= '0;
                  r_shift <= '0;
               end else begin
                  r_cnt   <= r_cnt + CNT_W'(1);
                  r_state <= S_START;
               end
            end
            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
               r_cnt   <= '0;
               r_shift <= '0;
            end
         endcase

         // output register: a held byte is only replaced when it is being accepted
         if (w_complete) begin
            if (!rx_valid || rx_ready) begin
               data_out <= r_shift;
               rx_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule
